// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
    localparam int          OP_MSB           = 31;
    localparam int          OP_LSB           = 26;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_instr_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs; flush wins over push/pop.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; consumers gate the head with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one read outstanding and buffers words for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic [31:0]        pc_plus4,
    output logic [5:0]         OP,
    output logic               misalign
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        misalign_reg, misalign_next;
    logic [31:0] pc_inc;
    logic        push, pop, credit;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic        fifo_empty, fifo_full;
    logic [31+INSTR_W:0] fifo_rdata;

    // pc_reg always holds the address of the request in flight (or next to issue).
    assign pc_inc      = pc_reg + PC_STEP;
    assign instr_valid = ~fifo_empty;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push        = (state_reg == WAIT) & imem_valid & ~redirect;
    assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    // A request needs a guaranteed slot for its response.
    assign credit      = push ? (occupancy < (CW+1)'(FIFO_DEPTH)) : (pop | ~fifo_full);

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32 + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({pc_reg, imem_rdata}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        misalign_next = misalign_reg;
        imem_req      = 1'b0;
        imem_addr     = pc_reg;
        if (redirect) begin
            pc_next       = word_align(redirect_target);
            misalign_next = misalign_reg | (|redirect_target[1:0]);
            state_next    = ((state_reg == WAIT || state_reg == DRAIN) && !imem_valid) ? DRAIN : ISSUE;
        end else begin
            case (state_reg)
                IDLE: state_next = ISSUE;
                ISSUE: begin
                    if (credit) begin
                        imem_req   = 1'b1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        pc_next = pc_inc;
                        if (credit) begin
                            imem_req  = 1'b1;
                            imem_addr = pc_inc;
                        end else begin
                            state_next = ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_valid) state_next = ISSUE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            pc_reg       <= PC_RESET;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
        end
    end

    assign instr    = instr_valid ? fifo_rdata[INSTR_W-1:0] : '0;
    assign instr_pc = instr_valid ? fifo_rdata[31+INSTR_W:INSTR_W] : '0;
    assign pc_plus4 = instr_valid ? fifo_rdata[31+INSTR_W:INSTR_W] + PC_STEP : '0;
    assign OP       = instr[OP_MSB:OP_LSB];
    assign misalign = misalign_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;

    localparam logic [31:0] PC0 = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  OP;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    int          mem_k = 1;          // 0 selects a random latency of 1..3 per request
    bit          mem_pending = 1'b0;
    bit          mem_resp = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_rdata = 32'h0;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .pc_plus4        (pc_plus4),
        .OP              (OP),
        .misalign        (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == PC0) return 32'h2008_0005;
        return {a[7:2], a[31:8] ^ 24'h5A3C96, 2'b01};
    endfunction

    // Memory: responds mem_k cycles after a request; inj_valid forces a stray response.
    always @(negedge clk) begin
        #1;
        mem_resp = 1'b0;
        if (!reset) mem_pending = 1'b0;
        else if (mem_pending) begin
            if (mem_cnt <= 1) begin
                mem_resp = 1'b1;
                mem_pending = 1'b0;
            end else mem_cnt = mem_cnt - 1;
        end
        imem_valid = mem_resp | inj_valid;
        imem_rdata = inj_valid ? inj_rdata : (mem_resp ? word(mem_addr) : 32'h0);
        #1;
        if (reset && imem_req) begin
            checks++;
            if (mem_pending) begin
                errors++;
                $display("FAIL one_outstanding: req at %h while %h still pending", imem_addr, mem_addr);
            end
            mem_pending = 1'b1;
            mem_cnt = (mem_k == 0) ? int'($urandom_range(1, 3)) : mem_k;
            mem_addr = imem_addr;
        end
    end

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b0; redirect = 1'b0; instr_ready = 1'b0; inj_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (instr_valid) begin ok = 1'b1; return; end
            cyc(); #2;
        end
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (imem_req) begin ok = 1'b1; return; end
            cyc(); #2;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; instr_ready = 1'b1;
        repeat (2) cyc();
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== PC0) begin errors++; $display("FAIL rst_addr: got %h want %h", imem_addr, PC0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want 0", pc_plus4); end
        checks++; if (OP !== 6'h0) begin errors++; $display("FAIL rst_op: got %h want 0", OP); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", misalign); end
    endtask

    task automatic test_stream;
        do_reset(); instr_ready = 1'b1; mem_k = 1; #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stream_idle_req: got %b want 0", imem_req); end
        for (int c = 1; c <= 5; c++) begin
            cyc(); #2;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== PC0 + 32'(4 * (c - 1))) begin
                errors++; $display("FAIL stream_addr c%0d: got req=%b addr=%h want %h", c, imem_req, imem_addr, PC0 + 32'(4 * (c - 1)));
            end
            if (c >= 3) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== PC0 + 32'(4 * (c - 3))) begin
                    errors++; $display("FAIL stream_pc c%0d: got v=%b pc=%h want %h", c, instr_valid, instr_pc, PC0 + 32'(4 * (c - 3)));
                end
            end
            if (c == 3) begin
                checks++;
                if (OP !== 6'h08 || instr !== 32'h2008_0005 || pc_plus4 !== PC0 + 32'd4) begin
                    errors++; $display("FAIL stream_op: got op=%h instr=%h pc4=%h want 08 20080005 %h", OP, instr, pc_plus4, PC0 + 32'd4);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int got;
        do_reset(); instr_ready = 1'b0; mem_k = 1; #2;
        for (int c = 1; c <= 8; c++) begin
            cyc(); #2;
            if (c >= 3) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req c%0d: got %b want 0", c, imem_req); end
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== PC0) begin
                    errors++; $display("FAIL bp_hold c%0d: got v=%b pc=%h want 1 %h", c, instr_valid, instr_pc, PC0);
                end
            end
        end
        got = 0;
        for (int n = 0; n < 12 && got < 3; n++) begin
            cyc(); instr_ready = 1'b1; #2;
            if (instr_valid) begin
                checks++;
                if (instr_pc !== PC0 + 32'(4 * got) || instr !== word(PC0 + 32'(4 * got))) begin
                    errors++; $display("FAIL bp_order #%0d: got pc=%h instr=%h want %h %h", got, instr_pc, instr, PC0 + 32'(4 * got), word(PC0 + 32'(4 * got)));
                end
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL bp_timeout: got %0d transfers want 3", got); end
    endtask

    task automatic test_drain;
        bit ok;
        do_reset(); instr_ready = 1'b1; mem_k = 3; #2;
        cyc(); #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== PC0) begin errors++; $display("FAIL drain_first: got req=%b addr=%h want 1 %h", imem_req, imem_addr, PC0); end
        cyc(); redirect = 1'b1; redirect_target = 32'h0040_0100; #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_redir_req: got %b want 0", imem_req); end
        for (int c = 3; c <= 4; c++) begin
            cyc(); redirect = 1'b0; #2;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_hold c%0d: got %b want 0", c, imem_req); end
        end
        cyc(); #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL drain_refetch: got req=%b addr=%h want 1 00400100", imem_req, imem_addr); end
        wait_valid(12, ok);
        checks++;
        if (!ok || instr_pc !== 32'h0040_0100 || instr !== word(32'h0040_0100)) begin
            errors++; $display("FAIL drain_word: got ok=%b pc=%h instr=%h want 00400100 %h", ok, instr_pc, instr, word(32'h0040_0100));
        end
    endtask

    task automatic test_redirect_on_valid;
        bit ok;
        do_reset(); instr_ready = 1'b1; mem_k = 1; #2;
        repeat (4) begin cyc(); #2; end
        cyc(); redirect = 1'b1; redirect_target = 32'h0040_0200; #2;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rov_pre: got v=%b want 1", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rov_req: got %b want 0", imem_req); end
        cyc(); redirect = 1'b0; #2;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rov_flush: got v=%b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL rov_addr: got req=%b addr=%h want 1 00400200", imem_req, imem_addr); end
        wait_valid(8, ok);
        checks++;
        if (!ok || instr_pc !== 32'h0040_0200 || instr !== word(32'h0040_0200)) begin
            errors++; $display("FAIL rov_word: got ok=%b pc=%h instr=%h want 00400200", ok, instr_pc, instr);
        end
    endtask

    task automatic test_misalign;
        bit ok;
        cyc(); redirect = 1'b1; redirect_target = 32'h0040_0102; #2;
        cyc(); redirect = 1'b0; #2;
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_set: got %b want 1", misalign); end
        wait_req(8, ok);
        checks++; if (!ok || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL mis_addr: got ok=%b addr=%h want 00400100", ok, imem_addr); end
        wait_valid(8, ok);
        checks++; if (!ok || instr_pc !== 32'h0040_0100) begin errors++; $display("FAIL mis_pc: got ok=%b pc=%h want 00400100", ok, instr_pc); end
        cyc(); redirect = 1'b1; redirect_target = 32'h0040_0300; #2;
        cyc(); redirect = 1'b0; #2;
        wait_valid(8, ok);
        checks++; if (!ok || instr_pc !== 32'h0040_0300) begin errors++; $display("FAIL mis_pc2: got ok=%b pc=%h want 00400300", ok, instr_pc); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b want 1", misalign); end
    endtask

    task automatic test_reset_midflight;
        bit ok;
        mem_k = 3; instr_ready = 1'b1;
        cyc(); #2;
        wait_req(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmf_noreq: got no request want one"); end
        cyc(); reset = 1'b0; #2;
        checks++; if (imem_req !== 1'b0 || imem_addr !== PC0) begin errors++; $display("FAIL rmf_req: got req=%b addr=%h want 0 %h", imem_req, imem_addr, PC0); end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || pc_plus4 !== 32'h0 || OP !== 6'h0) begin
            errors++; $display("FAIL rmf_outs: got v=%b i=%h pc=%h pc4=%h op=%h want zeros", instr_valid, instr, instr_pc, pc_plus4, OP);
        end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rmf_mis: got %b want 0", misalign); end
        cyc();
        cyc(); reset = 1'b1; inj_valid = 1'b1; inj_rdata = 32'hDEAD_BEEF; #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmf_idle: got req=%b want 0", imem_req); end
        cyc(); inj_valid = 1'b0; mem_k = 1; #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== PC0) begin errors++; $display("FAIL rmf_restart: got req=%b addr=%h want 1 %h", imem_req, imem_addr, PC0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmf_late: got v=%b want 0", instr_valid); end
        wait_valid(8, ok);
        checks++;
        if (!ok || instr_pc !== PC0 || instr !== 32'h2008_0005) begin
            errors++; $display("FAIL rmf_word: got ok=%b pc=%h instr=%h want %h 20080005", ok, instr_pc, instr, PC0);
        end
    endtask

    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] w;
        logic        exp_mis;
        int          transfers;
        int          sel;
        do_reset(); mem_k = 0; #2;
        exp_pc = PC0; exp_mis = 1'b0; transfers = 0;
        for (int n = 0; n < 800; n++) begin
            cyc();
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 19) == 0);
            sel = int'($urandom_range(0, 3));
            redirect_target = $urandom;
            if (sel == 0) redirect_target = 32'hFFFF_FFF0 | (redirect_target & 32'hF);
            else if (sel < 3) redirect_target = redirect_target & 32'hFFFF_FFFC;
            #2;
            checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rnd_mis n%0d: got %b want %b", n, misalign, exp_mis); end
            if (redirect) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_redir_req n%0d: got %b want 0", n, imem_req); end
                exp_pc = {redirect_target[31:2], 2'b00};
                exp_mis = exp_mis | (redirect_target[1:0] != 2'b00);
            end else if (instr_valid && instr_ready) begin
                w = word(exp_pc);
                checks++;
                if (instr_pc !== exp_pc || instr !== w || OP !== w[31:26] || pc_plus4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL rnd_xfer n%0d: got pc=%h i=%h op=%h pc4=%h want %h %h %h %h",
                                       n, instr_pc, instr, OP, pc_plus4, exp_pc, w, w[31:26], exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                transfers++;
            end
        end
        redirect = 1'b0;
        checks++; if (transfers < 50) begin errors++; $display("FAIL rnd_progress: got %0d transfers want >=50", transfers); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_redirect_on_valid();
        test_misalign();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the opcode decoder/control unit.
- Owns the PC register and issues one-outstanding read requests to instruction memory.
- Buffers returned words in a small FIFO and presents instruction, PC, PC+4 and the 6-bit opcode field to decode.
- Accepts taken-branch redirects from the branch-resolution logic driven by BranchEQ/BranchNE, and discards in-flight stale fetches.

Parameters:
PC_RESET, 32'h0040_0000, PC value loaded on reset (text segment base)
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  read request strobe, one cycle per request
imem_addr  out  32  word-aligned fetch address, valid when imem_req=1
imem_valid  in  1  response strobe for the single outstanding request
imem_rdata  in  32  instruction word, valid when imem_valid=1
redirect  in  1  taken branch: discard buffered/in-flight words, refetch from redirect_target
redirect_target  in  32  new PC
instr_valid  out  1  instr/instr_pc/OP hold a valid instruction
instr_ready  in  1  decode accepts the instruction this cycle
instr  out  32  FIFO head instruction
instr_pc  out  32  address of instr
pc_plus4  out  32  instr_pc + 4, modulo 2^32
OP  out  6  instr[31:26], consumed by the control unit
misalign  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=PC_RESET; FIFO empty; FSM=IDLE.
  - imem_req=0, imem_addr=PC_RESET, instr_valid=0, instr=0, instr_pc=0, pc_plus4=0, OP=0, misalign=0.
  - Asserting reset mid-request drops the request; a late imem_valid arriving after reset release is ignored (FSM in IDLE).
- FSM states:
  - IDLE: first cycle after reset release; go to ISSUE.
  - ISSUE: if credit, imem_req=1 and imem_addr=PC, then go to WAIT; else hold.
  - WAIT: on imem_valid, push {imem_rdata, PC} into the FIFO and set PC=PC+4. If credit is available in that same cycle, issue the next request (stay in WAIT); otherwise go to ISSUE.
  - DRAIN: a redirect occurred while a request was in flight. The next imem_valid is discarded, then go to ISSUE.
- Credit rule: a request may issue only if count + push - pop < FIFO_DEPTH, evaluated in the same cycle. This guarantees a slot for the response, so the FIFO never overflows.
- Latency: memory responds k>=1 cycles after the request. The word appears on instr_valid one cycle after imem_valid (registered FIFO, no bypass). Steady-state throughput with k=1 and instr_ready=1 is one instruction per cycle.
- Output handshake: transfer when instr_valid & instr_ready. instr, instr_pc and OP stay stable while instr_valid=1 and instr_ready=0.
- Redirect (highest priority, takes effect the same cycle):
  - FIFO flushed; any pop that cycle is ignored.
  - PC = {redirect_target[31:2], 2'b00}; misalign set if redirect_target[1:0] != 0.
  - Next state: DRAIN if a request is outstanding and not answered this cycle; otherwise ISSUE. No imem_req in the redirect cycle.
  - instr_valid=0 in the following cycle.
- Redirect in the same cycle as imem_valid: the response is discarded, and the FSM goes to ISSUE (not DRAIN).
- Back-to-back redirects: the last one wins; DRAIN is retained while the original request is still outstanding.
- PC wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
- misalign clears only on reset.

Decomposition:
- fetch_pkg:
  - state enum {IDLE, ISSUE, WAIT, DRAIN}
  - PC_RESET default
  - INSTR_W=32
  - OP_MSB=31, OP_LSB=26
  - PC_STEP=4
- Sub-module instr_fifo:
  - Parameterised depth/width; push, pop, flush inputs; count, empty, full outputs.
  - Width = 64 bits ({pc, instr}).
  - flush has priority over push/pop.

Test Plan:
- Reset release, k=1 memory, instr_ready=1 -> imem_addr 0x00400000, then 0x00400004, 0x00400008 on consecutive cycles. instr_pc follows 2 cycles behind; OP=6'h08 for word 0x2008_0005.
- instr_ready=0 for 6 cycles -> count reaches 2 and imem_req stays 0. On release, instr_pc = 0x00400000, 0x00400004, 0x00400008 with no loss or duplication.
- k=3 memory, redirect to 0x00400100 one cycle after a request -> stale word dropped; next instr_pc=0x00400100; FSM passes through DRAIN.
- Redirect coinciding with imem_valid and instr_ready=1 -> both words discarded; instr_valid=0 next cycle; next fetch address is the target.
- Redirect to 0x00400102 -> imem_addr=0x00400100 and misalign=1, which remains set through subsequent redirects.
- reset pulled low while in WAIT, then released -> outputs at reset values, fetch restarts at 0x00400000, and a late imem_valid during IDLE is ignored.
